acc_requant: RTL and testbench

- Drain-side counterpart of the sign-extended accumulate path.
- Accepts wide signed accumulated partial sums (ACC_W bits) from the CIM accumulator and narrows them to the PE operand width (OUT_W bits).
- Narrowing is a programmable arithmetic right shift with round-half-up, followed by signed saturation.
- Two-stage valid/ready pipeline with full backpressure, plus a saturation-event counter for calibration.

---
 rtl/acc_pkg.sv | 12 +
 rtl/acc_requant_sat_narrow.sv | 33 +++
 rtl/acc_requant.sv | 137 +++++++++++++
 tb/tb_acc_requant.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared defaults and output-range constants for the accumulator requantizer.
package acc_pkg;

  localparam int ACC_W_DEF = 51;
  localparam int OUT_W_DEF = 27;
  localparam int SH_W_DEF  = 6;
  localparam int CNT_W_DEF = 16;

  localparam logic signed [OUT_W_DEF-1:0] OUT_MAX = {1'b0, {(OUT_W_DEF-1){1'b1}}};
  localparam logic signed [OUT_W_DEF-1:0] OUT_MIN = {1'b1, {(OUT_W_DEF-1){1'b0}}};

endpackage

// File: rtl/acc_requant_sat_narrow.sv
// Combinational signed clip from IN_W to OW bits, flagging any clipped value.
module sat_narrow
  import acc_pkg::*;
#(
  parameter int IN_W = ACC_W_DEF + 1,
  parameter int OW   = OUT_W_DEF
) (
  input  logic [IN_W-1:0] q,
  output logic [OW-1:0]   y,
  output logic            sat
);

  // The value fits iff every bit from the output sign bit upward matches the input sign.
  logic [IN_W-OW:0] top_bits;
  assign top_bits = q[IN_W-1:OW-1];

  // Clip to the signed output range.
  always_comb begin
    y   = q[OW-1:0];
    sat = 1'b0;
    if (!q[IN_W-1] && (|top_bits)) begin
      y   = {1'b0, {(OW-1){1'b1}}};
      sat = 1'b1;
    end else if (q[IN_W-1] && !(&top_bits)) begin
      y   = {1'b1, {(OW-1){1'b0}}};
      sat = 1'b1;
    end else begin
      y   = q[OW-1:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/acc_requant.sv
// Two-stage valid/ready requantizer: round-half-up arithmetic shift, then signed
// saturation to the PE operand width, with a saturating clip-event counter.
module acc_requant
  import acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SH_W  = SH_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_data,
  input  logic [SH_W-1:0]  in_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_count
);

  localparam int RW = ACC_W + 1;

  logic             s1_valid_q, s1_valid_d;
  logic [RW-1:0]    s1_data_q, s1_data_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;
  logic [CNT_W-1:0] sat_count_q, sat_count_d;

  logic             adv1, in_fire, out_fire;
  logic [SH_W-1:0]  sh_eff;
  logic [RW-1:0]    addend, rsum, q_s1;
  logic [OUT_W-1:0] nar_data;
  logic             nar_sat;

  assign adv1     = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || adv1;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Stage-1 arithmetic: one guard bit keeps the rounding add from overflowing.
  always_comb begin
    if (int'(in_shift) >= ACC_W) begin
      sh_eff = SH_W'(ACC_W - 1);
    end else begin
      sh_eff = in_shift;
    end
    if (sh_eff == {SH_W{1'b0}}) begin
      addend = {RW{1'b0}};
    end else begin
      addend = {{(RW-1){1'b0}}, 1'b1} << (sh_eff - {{(SH_W-1){1'b0}}, 1'b1});
    end
    rsum = {in_data[ACC_W-1], in_data} + addend;
    q_s1 = $signed(rsum) >>> sh_eff;
  end

  sat_narrow #(
    .IN_W (RW),
    .OW   (OUT_W)
  ) u_sat_narrow (
    .q   (s1_data_q),
    .y   (nar_data),
    .sat (nar_sat)
  );

  // Pipeline next-state: s1 refills on accept, s2 reloads whenever it may advance.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = q_s1;
    end else if (adv1) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (adv1) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = nar_data;
        out_sat_d  = nar_sat;
      end else begin
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Clip-event counter: clear wins, increments stop at all-ones.
  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = {CNT_W{1'b0}};
    end else if (out_fire && out_sat_q && !(&sat_count_q)) begin
      sat_count_d = sat_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sat_count_d = sat_count_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= {RW{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {OUT_W{1'b0}};
      out_sat_q   <= 1'b0;
      sat_count_q <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_acc_requant.sv
// Directed self-checking bench for acc_requant: rounding, saturation,
// backpressure ordering, counter limits and mid-stream reset.
module tb_acc_requant;
  import acc_pkg::*;

  localparam longint P40 = 64'sd1099511627776;
  localparam longint P50 = 64'sd1125899906842624;

  typedef struct {
    longint d;
    int     sh;
    longint exp_v;
    logic   exp_sat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [50:0] in_data;
  logic [5:0]  in_shift;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] out_data;
  logic        out_sat;
  logic        sat_clr;
  logic [15:0] sat_count;

  int tests = 0;
  int fails = 0;

  acc_requant dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Sends one beat into an empty pipe and returns the result; starts and ends at a negedge.
  task automatic run_beat(input longint d, input int sh, output logic [26:0] got,
                          output logic got_sat, output int lat, output logic rdy);
    in_valid  = 1'b1;
    in_data   = d[50:0];
    in_shift  = sh[5:0];
    out_ready = 1'b1;
    #1 rdy = in_ready;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    got     = out_data;
    got_sat = out_sat;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_table(input string name, input vec_t v[]);
    logic [26:0] got;
    logic        gs;
    int          lat;
    logic        rdy;
    longint      e;
    for (int i = 0; i < v.size(); i++) begin
      run_beat(v[i].d, v[i].sh, got, gs, lat, rdy);
      e = v[i].exp_v;
      tests++;
      if (got !== e[26:0] || gs !== v[i].exp_sat || lat !== 2 || rdy !== 1'b1) begin
        fails++;
        $display("FAIL %s[%0d]: got data=%0d sat=%0b lat=%0d rdy=%0b, want data=%0d sat=%0b lat=2 rdy=1",
                 name, i, $signed(got), gs, lat, rdy, e, v[i].exp_sat);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0;
    out_ready = 1'b0; sat_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || out_data !== 27'd0 || out_sat !== 1'b0 ||
        sat_count !== 16'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: got valid=%0b data=%0d sat=%0b cnt=%0d rdy=%0b, want 0 0 0 0 1",
               out_valid, out_data, out_sat, sat_count, in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_round();
    vec_t v[] = '{'{1000, 2, 250, 1'b0}, '{1001, 2, 250, 1'b0},
                  '{1002, 2, 251, 1'b0}, '{1003, 2, 251, 1'b0}};
    run_table("round", v);
  endtask

  task automatic test_neg_tie();
    vec_t v[] = '{'{-5, 1, -2, 1'b0}, '{-6, 1, -3, 1'b0}, '{-1, 0, -1, 1'b0},
                  '{-7, 2, -2, 1'b0}};
    run_table("neg_tie", v);
  endtask

  task automatic test_saturate();
    vec_t v[] = '{'{P40, 0, 67108863, 1'b1}, '{-P40, 0, -67108864, 1'b1},
                  '{P50 - 1, 1, 67108863, 1'b1}};
    run_table("saturate", v);
    tests++;
    if (sat_count !== 16'd3) begin
      fails++;
      $display("FAIL sat_count_after_saturate: got %0d, want 3", sat_count);
    end
  endtask

  task automatic test_boundary();
    vec_t v[] = '{'{67108863, 0, 67108863, 1'b0}, '{-67108864, 0, -67108864, 1'b0},
                  '{67108864, 0, 67108863, 1'b1}, '{-67108865, 0, -67108864, 1'b1},
                  '{P50 - 1, 63, 1, 1'b0}, '{-P50, 50, -1, 1'b0}};
    run_table("boundary", v);
    tests++;
    if (sat_count !== 16'd5) begin
      fails++;
      $display("FAIL sat_count_after_boundary: got %0d, want 5", sat_count);
    end
  endtask

  task automatic test_backpressure();
    int          idx = 0;
    int          n = 0;
    logic        acc;
    logic [26:0] got[8];
    int          gc[8];
    out_ready = 1'b0;
    in_shift  = 6'd0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 51'(idx + 1);
      #1 acc = in_ready;
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
    end
    #1;
    tests++;
    if (idx !== 2 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept: got accepted=%0d in_ready=%0b, want 2 and 0", idx, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (idx < 4);
      in_data  = 51'(idx + 1);
      #1 acc = in_ready && in_valid;
      if (out_valid && n < 8) begin
        got[n] = out_data;
        gc[n]  = c;
        n++;
      end
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests++;
    if (n !== 4) begin
      fails++;
      $display("FAIL bp_count: got %0d outputs, want 4", n);
    end
    for (int i = 0; i < 4 && i < n; i++) begin
      tests++;
      if (got[i] !== 27'(i + 1) || gc[i] !== i) begin
        fails++;
        $display("FAIL bp_order[%0d]: got data=%0d cycle=%0d, want data=%0d cycle=%0d",
                 i, got[i], gc[i], i + 1, i);
      end
    end
  endtask

  task automatic test_counter();
    int          n = 0;
    int          cyc = 0;
    logic [26:0] got;
    logic        gs;
    int          lat;
    logic        rdy;
    sat_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sat_clr = 1'b0;
    tests++;
    if (sat_count !== 16'd0) begin
      fails++;
      $display("FAIL cnt_clear: got %0d, want 0", sat_count);
    end
    in_valid = 1'b1; in_data = P40[50:0]; in_shift = 6'd0; out_ready = 1'b1;
    while (n < 65538 && cyc < 70000) begin
      #1 if (out_valid) n++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests++;
    if (n !== 65538 || sat_count !== 16'hFFFF) begin
      fails++;
      $display("FAIL cnt_saturate: got transfers=%0d cnt=%0d, want 65538 and 65535", n, sat_count);
    end
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    sat_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sat_clr = 1'b0;
    tests++;
    if (sat_count !== 16'd0) begin
      fails++;
      $display("FAIL cnt_clr_priority: got %0d, want 0", sat_count);
    end
    run_beat(-P40, 0, got, gs, lat, rdy);
    tests++;
    if (sat_count !== 16'd1 || gs !== 1'b1) begin
      fails++;
      $display("FAIL cnt_after_clr: got cnt=%0d sat=%0b, want 1 and 1", sat_count, gs);
    end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1; in_shift = 6'd0; in_data = 51'd77;
    @(posedge clk);
    @(negedge clk);
    in_data = 51'd88;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_full: got in_ready=%0b out_valid=%0b, want 0 and 1", in_ready, out_valid);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sat_count !== 16'd0 || out_data !== 27'd0) begin
      fails++;
      $display("FAIL rstmid_state: got valid=%0b rdy=%0b cnt=%0d data=%0d, want 0 1 0 0",
               out_valid, in_ready, sat_count, out_data);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1 if (out_valid) seen = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_ghost: got stale beat=%0b, want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_round();
    test_neg_tie();
    test_saturate();
    test_boundary();
    test_backpressure();
    repeat (3) @(negedge clk);
    test_counter();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
